adc_avg_seq: RTL and testbench

//  Burst sequencer/averager around the dac_adc_1val conversion top. On run_i it

---
 rtl/adc_avg_seq_if.sv | 33 +++
 rtl/adc_avg_seq.sv | 129 ++++++++++++
 tb/tb_adc_avg_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/adc_avg_seq_if.sv
// rtl/adc_avg_seq_if.sv - handshake/data bundle between a burst client, the averager and the conversion top (ADC_MINMAX_EN adds min/max)
interface adc_avg_seq_if #(
  parameter int DATA_W = 12
);
  logic              run_i;
  logic              eoconv_i;
  logic [DATA_W-1:0] adc_data_i;
  logic              start_o;
  logic              busy_o;
  logic [DATA_W-1:0] avg_o;
  logic              avg_valid_o;
  logic              timeout_o;
`ifdef ADC_MINMAX_EN
  logic [DATA_W-1:0] min_o;
  logic [DATA_W-1:0] max_o;
`endif

  modport master (
    output run_i, eoconv_i, adc_data_i,
    input  start_o, busy_o, avg_o, avg_valid_o, timeout_o
`ifdef ADC_MINMAX_EN
    , input min_o, max_o
`endif
  );

  modport slave (
    input  run_i, eoconv_i, adc_data_i,
    output start_o, busy_o, avg_o, avg_valid_o, timeout_o
`ifdef ADC_MINMAX_EN
    , output min_o, max_o
`endif
  );
endinterface

// File: rtl/adc_avg_seq.sv
// rtl/adc_avg_seq.sv - burst sequencer issuing 2^LOG2_N conversions and reporting their truncated mean (ADC_MINMAX_EN adds min/max)
module adc_avg_seq #(
  parameter int DATA_W      = 12,
  parameter int LOG2_N      = 4,
  parameter int GAP_CYC     = 100,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           clk_i,
  input  logic           rst_i,
  adc_avg_seq_if.slave   bus
);
  localparam int ACC_W   = DATA_W + LOG2_N;
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_GAP, S_DONE, S_ABORT} state_t;

  state_t             state_q, state_d;
  logic               eoconv_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_next;
  logic [LOG2_N-1:0]  smp_cnt_q;
  logic [CNT_W-1:0]   cyc_cnt_q;
  logic [DATA_W-1:0]  avg_q;
  logic               timeout_q;
  logic               ev;
  logic               last_smp;
  logic               tmo_hit;
  logic               gap_hit;

  assign ev       = bus.eoconv_i & ~eoconv_q;
  assign last_smp = (smp_cnt_q == {LOG2_N{1'b1}});
  assign tmo_hit  = (cyc_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign gap_hit  = (cyc_cnt_q == CNT_W'(GAP_CYC - 1));
  assign acc_next = acc_q + ACC_W'(bus.adc_data_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.run_i) state_d = S_TRIG;
      S_TRIG:  state_d = S_WAIT;
      // A sample arriving on the timeout terminal count is still accepted.
      S_WAIT: begin
        if (ev)           state_d = last_smp ? S_DONE : S_GAP;
        else if (tmo_hit) state_d = S_ABORT;
      end
      S_GAP:   if (gap_hit) state_d = S_TRIG;
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ADC_MINMAX_EN
  logic [DATA_W-1:0] min_q, max_q, min_trk_q, max_trk_q;
  logic [DATA_W-1:0] min_next, max_next;

  // The first sample of a burst seeds both trackers.
  assign min_next = (smp_cnt_q == '0 || bus.adc_data_i < min_trk_q) ? bus.adc_data_i : min_trk_q;
  assign max_next = (smp_cnt_q == '0 || bus.adc_data_i > max_trk_q) ? bus.adc_data_i : max_trk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q     <= '0;
      max_q     <= '0;
      min_trk_q <= '0;
      max_trk_q <= '0;
    end else if (state_q == S_WAIT && ev) begin
      min_trk_q <= min_next;
      max_trk_q <= max_next;
      if (last_smp) begin
        min_q <= min_next;
        max_q <= max_next;
      end
    end
  end

  assign bus.min_o = min_q;
  assign bus.max_o = max_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eoconv_q  <= 1'b0;
      acc_q     <= '0;
      smp_cnt_q <= '0;
      cyc_cnt_q <= '0;
      avg_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      eoconv_q <= bus.eoconv_i;
      case (state_q)
        S_IDLE: begin
          if (bus.run_i) begin
            acc_q     <= '0;
            smp_cnt_q <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_TRIG: cyc_cnt_q <= '0;
        S_WAIT: begin
          if (ev) begin
            acc_q     <= acc_next;
            smp_cnt_q <= smp_cnt_q + 1'b1;
            cyc_cnt_q <= '0;
            // Mean taken from the updated sum so the final sample is included.
            if (last_smp) avg_q <= acc_next[ACC_W-1:LOG2_N];
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end
        end
        S_GAP:   cyc_cnt_q <= cyc_cnt_q + 1'b1;
        S_ABORT: timeout_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.start_o     = (state_q == S_TRIG);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.avg_valid_o = (state_q == S_DONE);
  assign bus.avg_o       = avg_q;
  assign bus.timeout_o   = timeout_q;
endmodule

// File: tb/tb_adc_avg_seq.sv
// tb/tb_adc_avg_seq.sv - directed bench for adc_avg_seq with a behavioural eoconv model (ADC_MINMAX_EN adds min/max checks)
module tb_adc_avg_seq;
  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_avg_seq_if #(.DATA_W(DATA_W)) bus();

  adc_avg_seq #(
    .DATA_W(DATA_W), .LOG2_N(2), .GAP_CYC(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_valid = 0;
  logic [DATA_W-1:0] last_avg;
  logic [DATA_W-1:0] samp_q[$];
  bit model_en = 1'b1;
  int hold     = 1;
  bit extra    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.start_o) n_start++;
    if (bus.avg_valid_o) begin
      n_valid++;
      last_avg = bus.avg_o;
    end
  end

  // Conversion model: result ~40 cycles after each start pulse, optional long hold and stray pulse.
  initial begin
    bus.eoconv_i   = 1'b0;
    bus.adc_data_i = '0;
    forever begin
      @(negedge clk);
      if (bus.start_o && model_en && samp_q.size() > 0) begin
        repeat (40) @(posedge clk);
        #1 bus.adc_data_i = samp_q.pop_front();
        bus.eoconv_i = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.eoconv_i = 1'b0;
        if (extra) begin
          @(posedge clk);
          #1 bus.eoconv_i = 1'b1;
          bus.adc_data_i = 12'hFFF;
          @(posedge clk);
          #1 bus.eoconv_i = 1'b0;
        end
      end
    end
  end

  task automatic run_pulse(input string tag);
    @(posedge clk);
    #1 bus.run_i = 1'b1;
    @(posedge clk);
    #1 bus.run_i = 1'b0;
    check({tag, " start latency"}, bus.start_o, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!bus.busy_o) return;
    end
    check("idle wait", bus.busy_o, 0);
  endtask

  task automatic burst(input string tag, input logic [DATA_W-1:0] s0, s1, s2, s3,
                       input logic [DATA_W-1:0] exp_avg);
    samp_q = '{s0, s1, s2, s3};
    n_start = 0;
    n_valid = 0;
    run_pulse(tag);
    wait_idle();
    check({tag, " avg"}, last_avg, exp_avg);
    check({tag, " valid cnt"}, n_valid, 1);
    check({tag, " start cnt"}, n_start, 4);
  endtask

  initial begin
    rst = 1'b1;
    bus.run_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst start", bus.start_o, 0);
    check("rst busy", bus.busy_o, 0);
    check("rst avg", bus.avg_o, 0);
    check("rst valid", bus.avg_valid_o, 0);
    check("rst timeout", bus.timeout_o, 0);
`ifdef ADC_MINMAX_EN
    check("rst min", bus.min_o, 0);
    check("rst max", bus.max_o, 0);
`endif

    burst("basic", 100, 200, 300, 400, 250);
    check("basic avg held", bus.avg_o, 250);
    burst("fullscale", 4095, 4095, 4095, 4095, 4095);
    burst("trunc", 1, 1, 1, 2, 1);

    model_en = 1'b0;
    n_start = 0;
    n_valid = 0;
    run_pulse("tmo");
    repeat (60) @(posedge clk);
    #1 check("tmo early", bus.timeout_o, 0);
    check("tmo early busy", bus.busy_o, 1);
    repeat (8) @(posedge clk);
    #1 check("tmo set", bus.timeout_o, 1);
    check("tmo idle", bus.busy_o, 0);
    check("tmo no valid", n_valid, 0);
    check("tmo one start", n_start, 1);
    check("tmo avg kept", bus.avg_o, 1);
    model_en = 1'b1;
    samp_q = '{12, 12, 16, 16};
    n_start = 0;
    run_pulse("clr");
    check("tmo cleared", bus.timeout_o, 0);
    wait_idle();
    check("clr avg", last_avg, 14);

    samp_q = '{40, 41, 42, 43};
    n_start = 0;
    n_valid = 0;
    run_pulse("ignore");
    repeat (10) @(posedge clk);
    #1 bus.run_i = 1'b1;
    @(posedge clk);
    #1 bus.run_i = 1'b0;
    wait_idle();
    check("ignore avg", last_avg, 41);
    check("ignore start cnt", n_start, 4);
    check("ignore valid cnt", n_valid, 1);

    samp_q = '{500, 600, 700, 800};
    n_valid = 0;
    run_pulse("reset");
    for (int i = 0; i < 400 && !(samp_q.size() == 2 && !bus.eoconv_i); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("mid rst busy", bus.busy_o, 0);
    check("mid rst avg", bus.avg_o, 0);
    check("mid rst start", bus.start_o, 0);
    check("mid rst timeout", bus.timeout_o, 0);
    rst = 1'b0;
    check("mid rst no valid", n_valid, 0);
    burst("post rst", 8, 8, 8, 8, 8);

    hold  = 3;
    extra = 1'b1;
    burst("hold", 10, 20, 30, 40, 25);
    hold  = 1;
    extra = 1'b0;

`ifdef ADC_MINMAX_EN
    burst("minmax", 7, 3, 9, 5, 6);
    check("minmax min", bus.min_o, 3);
    check("minmax max", bus.max_o, 9);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
